// File: rtl/reg_mem_fifo_ctrl.sv
// reg_mem_fifo_ctrl: valid/ready FIFO controller that owns the single reg_mem port.
// Memory holds 2**ADDR_BITS words; a registered output stage holds one more.
module reg_mem_fifo_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [ADDR_BITS-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic [ADDR_BITS:0]    count,
   output logic                  full,
   output logic                  empty
);
   localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS+1)'(2**ADDR_BITS);
   logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_BITS:0]    mem_cnt_q, mem_cnt_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  rd_sel, wr_fire;
   // Refilling the output register takes the port ahead of any producer write.
   always_comb begin
      rd_sel      = (mem_cnt_q != '0) && (!out_valid_q || out_ready);
      full        = mem_cnt_q == DEPTH;
      in_ready    = rst_n && !full && !rd_sel;
      wr_fire     = in_valid && in_ready;
      mem_wen     = wr_fire;
      mem_addr    = wr_fire ? wr_ptr_q : rd_ptr_q;
      mem_data_in = in_data;
      count       = mem_cnt_q + (ADDR_BITS+1)'(out_valid_q);
      empty       = count == '0;
      out_valid   = out_valid_q;
      out_data    = out_data_q;
      wr_ptr_d    = wr_fire ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
      rd_ptr_d    = rd_sel ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;
      mem_cnt_d   = wr_fire ? mem_cnt_q + (ADDR_BITS+1)'(1) :
                    rd_sel  ? mem_cnt_q - (ADDR_BITS+1)'(1) : mem_cnt_q;
      out_valid_d = rd_sel || (out_valid_q && !out_ready);
      out_data_d  = rd_sel ? mem_data_out : out_data_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_cnt_q   <= mem_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end
endmodule

// File: tb/tb_reg_mem_fifo_ctrl.sv
// tb_reg_mem_fifo_ctrl: queue-based reference model checked every cycle, plus directed
// literal expectations for fill, drain, wrap, port collision and mid-operation reset.
module tb_reg_mem_fifo_ctrl;
   localparam int DEPTH = 32;
   logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready, out_valid, mem_wen, full, empty;
   logic [7:0] out_data, mem_data_in, mem_data_out;
   logic [4:0] mem_addr;
   logic [5:0] count;
   logic [7:0] mem [DEPTH];
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   reg_mem_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .mem_wen(mem_wen), .mem_data_out(mem_data_out),
      .count(count), .full(full), .empty(empty));

   // reg_mem stand-in: synchronous write, combinational read, contents survive reset
   always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_data_in;
   assign mem_data_out = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   logic [7:0] mq[$];
   logic       m_ov = 1'b0;
   logic [7:0] m_od = 8'd0;
   int         m_wc = 0, m_rc = 0;
   logic       p_rd = 1'b0, p_wf = 1'b0, p_or = 1'b0;
   logic [7:0] p_d = 8'd0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete(); m_ov = 1'b0; m_od = 8'd0; m_wc = 0; m_rc = 0;
      end else begin
         if (p_rd) begin m_od = mq.pop_front(); m_ov = 1'b1; m_rc++; end
         else if (p_or) m_ov = 1'b0;
         if (p_wf) begin mq.push_back(p_d); m_wc++; end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_count", count, 0);
         chk("rst_empty", empty, 1);
         chk("rst_full", full, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_mem_wen", mem_wen, 0);
         p_rd = 1'b0; p_wf = 1'b0; p_or = 1'b0;
      end else begin : mdl
         int   mc;
         logic rd, fl, ir, wf;
         mc = mq.size();
         rd = (mc != 0) && (!m_ov || out_ready);
         fl = mc == DEPTH;
         ir = !fl && !rd;
         wf = in_valid && ir;
         chk("m_count", count, mc + int'(m_ov));
         chk("m_full", full, fl);
         chk("m_empty", empty, (mc + int'(m_ov)) == 0);
         chk("m_out_valid", out_valid, m_ov);
         if (m_ov) chk("m_out_data", out_data, m_od);
         chk("m_in_ready", in_ready, ir);
         chk("m_mem_wen", mem_wen, wf);
         if (wf) begin
            chk("m_wr_addr", mem_addr, m_wc % DEPTH);
            chk("m_wr_data", mem_data_in, in_data);
         end else if (rd) chk("m_rd_addr", mem_addr, m_rc % DEPTH);
         p_rd = rd; p_wf = wf; p_d = in_data; p_or = out_ready;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic push(input logic [7:0] v);
      logic ok;
      ok = 1'b0;
      in_valid = 1'b1; in_data = v;
      for (int k = 0; k < 80 && !ok; k++) begin
         @(negedge clk); ok = in_ready;
         step();
      end
      in_valid = 1'b0;
      chk("push_accept", ok, 1);
   endtask

   task automatic expect_out(input string name, input logic [7:0] v);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk); seen = out_valid;
         if (seen) chk(name, out_data, v);
         step();
      end
      chk({name, "_seen"}, seen, 1);
   endtask

   initial begin
      int sent, recv, got;
      // T1: reset
      repeat (3) @(posedge clk);
      #3;
      chk("t1_in_ready_low", in_ready, 0);
      chk("t1_empty", empty, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      #1 chk("t1_in_ready_rel", in_ready, 1);
      // T2: fill to DEPTH+1 with the consumer stalled
      out_ready = 1'b0;
      for (int v = 10; v <= 42; v++) push(8'(v));
      @(negedge clk);
      chk("t2_out_data", out_data, 10);
      chk("t2_count", count, 33);
      chk("t2_full", full, 1);
      chk("t2_in_ready", in_ready, 0);
      step();
      in_valid = 1'b1; in_data = 8'd99;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_held_ready", in_ready, 0);
         chk("t2_held_wen", mem_wen, 0);
         step();
      end
      in_valid = 1'b0;
      // T3: drain in order, then the held word goes through
      out_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 80 && got < 33; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin chk("t3_order", out_data, 10 + got); got++; end
         step();
      end
      chk("t3_drained", got, 33);
      @(negedge clk);
      chk("t3_out_valid", out_valid, 0);
      chk("t3_empty", empty, 1);
      chk("t3_count", count, 0);
      step();
      push(8'd99);
      expect_out("t3_late99", 8'd99);
      // T4: random interleaving of 100 words across several pointer wraps
      sent = 0; recv = 0;
      for (int c = 0; c < 3000 && recv < 100; c++) begin
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_data   = 8'(sent);
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin chk("t4_order", out_data, recv); recv++; end
         step();
      end
      in_valid = 1'b0;
      chk("t4_recv", recv, 100);
      // T5: two words in memory, consumer and producer both active
      out_ready = 1'b1;
      repeat (40) step();
      out_ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk);
      chk("t5_c1_ready", in_ready, 0); chk("t5_c1_wen", mem_wen, 0); chk("t5_c1_data", out_data, 8'h11);
      step();
      @(negedge clk);
      chk("t5_c2_ready", in_ready, 0); chk("t5_c2_wen", mem_wen, 0); chk("t5_c2_data", out_data, 8'h22);
      step();
      @(negedge clk);
      chk("t5_c3_ready", in_ready, 1); chk("t5_c3_wen", mem_wen, 1); chk("t5_c3_data", out_data, 8'h33);
      step();
      in_valid = 1'b0;
      expect_out("t5_landed", 8'h55);
      // T6: asynchronous reset with 17 words held
      out_ready = 1'b0;
      for (int v = 0; v < 17; v++) push(8'(200 + v));
      @(negedge clk);
      chk("t6_count17", count, 17);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_in_ready", in_ready, 0);
      chk("t6_mem_wen", mem_wen, 0);
      chk("t6_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      push(8'd5);
      expect_out("t6_fresh", 8'd5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
